// File: rtl/bus_pkg.sv
// Shared types, address-map constants and region decode for mem_bus_ctrl.
package bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_ACC,
    S_EXT_WAIT,
    S_DRIVE,
    S_HOLD
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_EXT,
    REG_IO,
    REG_UNMAPPED
  } region_t;

  localparam logic [15:0] RAM_END       = 16'h1FFF;
  localparam logic [15:0] EXT_BASE      = 16'h2000;
  localparam logic [15:0] EXT_END       = 16'hFEFF;
  localparam logic [15:0] IO_ADDR       = 16'hFF00;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

  // io_en selects whether IO_ADDR decodes as the output port or as unmapped.
  function automatic region_t decode_region(input logic [15:0] addr, input logic io_en);
    if (addr <= RAM_END)
      return REG_RAM;
    else if (addr >= EXT_BASE && addr <= EXT_END)
      return REG_EXT;
    else if (io_en && addr == IO_ADDR)
      return REG_IO;
    else
      return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous data RAM, 2**AW x 8, one-cycle read latency, no reset.
module bus_ram #(
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Write or registered read on an enabled cycle; rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side memory/bus controller: decodes the CPU address, serves internal RAM,
// external memory (req/ack with timeout) and an optional output port, and
// drives the shared data bus back to the CPU.
// Optional feature: define BUS_IO_PORT_EN to map the io_port register at 0xFF00.
module mem_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned RAM_AW      = 13,
  parameter int unsigned EXT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adress_bus,
  inout  wire  [7:0]  date_bus,
  input  logic        r,
  input  logic        w,
  output logic        ready,
  output logic        bus_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack
`ifdef BUS_IO_PORT_EN
  ,
  output logic [7:0]  io_port
`endif
);

`ifdef BUS_IO_PORT_EN
  localparam logic IO_EN = 1'b1;
`else
  localparam logic IO_EN = 1'b0;
`endif

  localparam logic [7:0] TO_LAST = 8'(EXT_TIMEOUT - 1);

  bus_state_t  state_q, state_d;
  region_t     region;
  logic [15:0] addr_q;
  logic        dir_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_q;
  logic        src_ram_q;
  logic [7:0]  cnt_q;
  logic        ext_req_q;
  logic        err_q;
  logic        conflict_q;
  logic        timeout;
  logic        busy;
  logic [7:0]  ram_rdata;
  logic [7:0]  rd_data;
`ifdef BUS_IO_PORT_EN
  logic [7:0]  io_q;
`endif

  assign region  = decode_region(adress_bus, IO_EN);
  assign timeout = (cnt_q == TO_LAST);

  bus_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (state_q == S_RAM_ACC),
    .we    (dir_q),
    .addr  (addr_q[RAM_AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state decode; ack takes priority over timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!conflict_q && (r ^ w)) begin
          unique case (region)
            REG_RAM: state_d = S_RAM_ACC;
            REG_EXT: state_d = S_EXT_WAIT;
            default: state_d = r ? S_DRIVE : S_HOLD;
          endcase
        end
      end
      S_RAM_ACC:  state_d = dir_q ? S_HOLD : S_DRIVE;
      S_EXT_WAIT: if (ext_ack || timeout) state_d = dir_q ? S_HOLD : S_DRIVE;
      S_DRIVE:    if (!r) state_d = S_IDLE;
      S_HOLD:     if (!w) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Ready drops combinationally on the strobe cycle so the strobe-to-ready
  // latency includes the capture cycle; reset forces it high asynchronously.
  always_comb begin
    busy  = (state_q == S_IDLE && !conflict_q && (r ^ w)) ||
            (state_q == S_RAM_ACC) || (state_q == S_EXT_WAIT);
    ready = !reset || !busy;
  end

  // State register plus access capture, external handshake and error tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dir_q      <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      src_ram_q  <= 1'b0;
      cnt_q      <= '0;
      ext_req_q  <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
`ifdef BUS_IO_PORT_EN
      io_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (r && w) begin
            err_q      <= 1'b1;
            conflict_q <= 1'b1;
          end else if (!r && !w) begin
            conflict_q <= 1'b0;
          end else if (!conflict_q) begin
            addr_q    <= adress_bus;
            dir_q     <= w;
            wdata_q   <= date_bus;
            cnt_q     <= '0;
            src_ram_q <= (region == REG_RAM);
            ext_req_q <= (region == REG_EXT);
`ifdef BUS_IO_PORT_EN
            rd_q <= (region == REG_IO) ? io_q : UNMAPPED_DATA;
            if (region == REG_IO && w) io_q <= date_bus;
`else
            rd_q <= UNMAPPED_DATA;
`endif
          end
        end
        S_EXT_WAIT: begin
          if (ext_ack) begin
            ext_req_q <= 1'b0;
            rd_q      <= ext_rdata;
          end else if (timeout) begin
            ext_req_q <= 1'b0;
            err_q     <= 1'b1;
            rd_q      <= UNMAPPED_DATA;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data   = src_ram_q ? ram_rdata : rd_q;
  assign date_bus  = (state_q == S_DRIVE) ? rd_data : 8'bz;
  assign bus_err   = err_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = dir_q;
  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;
`ifdef BUS_IO_PORT_EN
  assign io_port   = io_q;
`endif

endmodule
